// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback_pkg
// Brief   : Shared widths and the buffered write-back entry type.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_writeback_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback_if
// Brief   : Valid/ready result handshake from execute/memory into write-back.
// Revision: 1.0 - initial release
// ============================================================================
interface regfile_writeback_if;
  import regfile_writeback_pkg::*;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;

  modport master (output wb_valid, output wb_rd, output wb_data, input  wb_ready);
  modport slave  (input  wb_valid, input  wb_rd, input  wb_data, output wb_ready);

endinterface
`default_nettype wire

// File: rtl/regfile_writeback_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : In-order result FIFO exposing storage and per-slot occupancy.
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              push,
  input  wb_entry_t        push_entry,
  input  wire              pop,
  output wb_entry_t        mem_o [DEPTH],
  output logic [DEPTH-1:0] slot_valid_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push && !full_o;
  assign do_pop  = pop && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot_valid
    logic [PTR_W-1:0] offset;
    assign offset          = PTR_W'(i) - rd_ptr_q;
    assign slot_valid_o[i] = ({1'b0, offset} < count_q);
  end

  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback
// Brief   : Buffered write-back front end for the RV32I register file; filters
//           x0, honours wb_hold, exports busy_mask. Optional result forwarding
//           is enabled by defining WB_FORWARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire                   clk,
  input  wire                   reset,
  regfile_writeback_if.slave    wb,
  input  wire                   wb_hold,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3,
  output logic                  RegWrite,
  output logic [NUM_REGS-1:0]   busy_mask
`ifdef WB_FORWARD_EN
  ,
  input  wire  [REG_ADDR_W-1:0] fwd_a1,
  input  wire  [REG_ADDR_W-1:0] fwd_a2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  wb_entry_t        head;
  wb_entry_t        push_entry;
  logic [DEPTH-1:0] slot_valid;
  logic [PTR_W-1:0] rd_ptr;
  logic             full, empty, push, pop;

  // Writes to x0 complete the handshake but are never stored.
  assign wb.wb_ready = !full;
  assign push        = wb.wb_valid && !full && (wb.wb_rd != '0);
  assign pop         = !empty && !wb_hold;
  assign push_entry  = '{rd: wb.wb_rd, data: wb.wb_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .mem_o        (mem),
    .slot_valid_o (slot_valid),
    .rd_ptr_o     (rd_ptr),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign head     = mem[rd_ptr];
  assign RegWrite = pop;
  assign A3       = empty ? '0 : head.rd;
  assign WD3      = empty ? '0 : head.data;

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        busy_mask[mem[i].rd] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] fwd_slot;

  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    fwd_slot  = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_slot = rd_ptr + PTR_W'(k);
      if (slot_valid[fwd_slot] && (fwd_a1 != '0) && (mem[fwd_slot].rd == fwd_a1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = mem[fwd_slot].data;
      end
      if (slot_valid[fwd_slot] && (fwd_a2 != '0) && (mem[fwd_slot].rd == fwd_a2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = mem[fwd_slot].data;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_writeback
// Brief   : Directed plus random checks of regfile_writeback against a
//           queue-based model (forwarding checks under WB_FORWARD_EN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_hold;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        RegWrite;
  logic [31:0] busy_mask;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_a1 = '0;
  logic [4:0]  fwd_a2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int checks = 0;
  int errors = 0;
  wb_entry_t model_q[$];

  regfile_writeback_if wb_bus ();

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (wb_bus),
    .wb_hold   (wb_hold),
    .A3        (A3),
    .WD3       (WD3),
    .RegWrite  (RegWrite),
    .busy_mask (busy_mask)
`ifdef WB_FORWARD_EN
    ,
    .fwd_a1    (fwd_a1),
    .fwd_a2    (fwd_a2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

`ifdef WB_FORWARD_EN
  function automatic void ref_fwd(input logic [4:0] a, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (a != 0) begin
      foreach (model_q[i]) begin
        if (model_q[i].rd == a) begin
          hit  = 1'b1;
          data = model_q[i].data;
        end
      end
    end
  endfunction
`endif

  task automatic check_outputs(input string ctx);
    logic [31:0] exp_busy;
    logic        has;
`ifdef WB_FORWARD_EN
    logic        eh;
    logic [31:0] ed;
`endif
    exp_busy = '0;
    foreach (model_q[i]) exp_busy[model_q[i].rd] = 1'b1;
    has = (model_q.size() != 0);
    chk({ctx, ".ready"},    wb_bus.wb_ready, model_q.size() != DEPTH);
    chk({ctx, ".regwrite"}, RegWrite, has && !wb_hold);
    chk({ctx, ".a3"},       A3,  has ? model_q[0].rd   : 5'd0);
    chk({ctx, ".wd3"},      WD3, has ? model_q[0].data : 32'd0);
    chk({ctx, ".busy"},     busy_mask, exp_busy);
`ifdef WB_FORWARD_EN
    ref_fwd(fwd_a1, eh, ed);
    chk({ctx, ".hit1"},  fwd_hit1, eh);
    chk({ctx, ".data1"}, fwd_data1, ed);
    ref_fwd(fwd_a2, eh, ed);
    chk({ctx, ".hit2"},  fwd_hit2, eh);
    chk({ctx, ".data2"}, fwd_data2, ed);
`endif
  endtask

  // One clock: drive at negedge, check state-derived outputs, advance model at posedge.
  task automatic cycle(input logic rst, input logic v, input logic [4:0] a_rd,
                       input logic [31:0] a_data, input logic h, input string ctx);
    logic      do_pop, do_push;
    wb_entry_t e;
    reset           = rst;
    wb_bus.wb_valid = v;
    wb_bus.wb_rd    = a_rd;
    wb_bus.wb_data  = a_data;
    wb_hold         = h;
    #1;
    check_outputs(ctx);
    do_pop  = (model_q.size() != 0) && !h;
    do_push = v && (model_q.size() != DEPTH) && (a_rd != 0);
    e.rd    = a_rd;
    e.data  = a_data;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    wb_hold         = 1'b0;
    wb_bus.wb_valid = 1'b0;
    wb_bus.wb_rd    = '0;
    wb_bus.wb_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.ready",    wb_bus.wb_ready, 1);
    chk("rst.regwrite", RegWrite, 0);
    chk("rst.a3",       A3, 0);
    chk("rst.wd3",      WD3, 0);
    chk("rst.busy",     busy_mask, 0);
    @(negedge clk);

    // Single push: commit appears the following cycle
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, "push5");
    chk("lat.regwrite", RegWrite, 1);
    chk("lat.a3",       A3, 5);
    chk("lat.wd3",      WD3, 32'hDEADBEEF);
    chk("lat.busy",     busy_mask, 32'h20);
    cycle(0, 0, 5'd0, 32'h0, 0, "lat_idle");
    chk("lat.after_rw",   RegWrite, 0);
    chk("lat.after_busy", busy_mask, 0);

    // x0 write is accepted but dropped
    cycle(0, 1, 5'd0, 32'h1234, 0, "x0");
    chk("x0.ready",    wb_bus.wb_ready, 1);
    chk("x0.regwrite", RegWrite, 0);
    chk("x0.busy",     busy_mask, 0);

    // Fill under hold, reject extra push, then drain in order
    for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 5'(i), 32'h100 + i, 1, "fill");
    chk("full.ready", wb_bus.wb_ready, 0);
    chk("full.busy",  busy_mask, 32'h1E);
    cycle(0, 1, 5'd9, 32'h999, 1, "push_full");
    chk("full.busy_no9", busy_mask, 32'h1E);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain.a3", A3, 5'(i));
      cycle(0, 0, 5'd0, 32'h0, 0, "drain");
    end
    chk("drain.done_rw",   RegWrite, 0);
    chk("drain.done_busy", busy_mask, 0);

    // Full with a pop in the same cycle: push rejected, then accepted next cycle
    for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 5'(i + 10), 32'h200 + i, 1, "fill2");
    cycle(0, 1, 5'd20, 32'hA0A0, 0, "full_pop");
    chk("full_pop.ready", wb_bus.wb_ready, 1);
    cycle(0, 1, 5'd20, 32'hA0A0, 0, "full_retry");
    repeat (DEPTH + 1) cycle(0, 0, 5'd0, 32'h0, 0, "drain2");
    chk("drain2.busy", busy_mask, 0);

`ifdef WB_FORWARD_EN
    fwd_a1 = 5'd7;
    fwd_a2 = 5'd0;
    cycle(0, 1, 5'd7, 32'h11, 1, "fwd_a");
    cycle(0, 1, 5'd7, 32'h22, 1, "fwd_b");
    #1;
    chk("fwd.hit1",  fwd_hit1, 1);
    chk("fwd.data1", fwd_data1, 32'h22);
    chk("fwd.hit2",  fwd_hit2, 0);
    repeat (3) cycle(0, 0, 5'd0, 32'h0, 0, "fwd_drain");
`endif

    // Reset with three entries buffered discards them
    cycle(0, 1, 5'd3, 32'h33, 1, "pre_rst");
    cycle(0, 1, 5'd4, 32'h44, 1, "pre_rst");
    cycle(0, 1, 5'd6, 32'h66, 1, "pre_rst");
    chk("pre_rst.busy", busy_mask, 32'h58);
    cycle(1, 0, 5'd0, 32'h0, 1, "in_rst");
    wb_hold = 1'b0;
    #1;
    chk("post_rst.regwrite", RegWrite, 0);
    chk("post_rst.busy",     busy_mask, 0);
    chk("post_rst.ready",    wb_bus.wb_ready, 1);
    @(negedge clk);
    repeat (3) cycle(0, 0, 5'd0, 32'h0, 0, "post_rst_idle");

    // Random traffic against the queue model
    for (int n = 0; n < 600; n++) begin
`ifdef WB_FORWARD_EN
      fwd_a1 = 5'($urandom_range(0, 7));
      fwd_a2 = 5'($urandom_range(0, 7));
`endif
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 2) == 0),
            "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
